// File: rtl/psi_channel_scheduler.sv
// Round-robin scheduler sharing one reafference/ERN/PID/QGH core among NCH
// sensor-motor channels, with per-channel veto lockout and a WAIT timeout.

module psi_lock_lane #(
    parameter int LW   = 7,
    parameter int HOLD = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic free
);
    logic [LW-1:0] cnt;

    // A load wins over the running decrement in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= LW'(HOLD);
        else if (cnt != '0)
            cnt <= cnt - LW'(1);
    end

    assign free = (cnt == '0);
endmodule

module psi_channel_scheduler #(
    parameter int NCH       = 4,
    parameter int W         = 16,
    parameter int TIMEOUT   = 15,
    parameter int VETO_HOLD = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_req,
    input  logic [NCH*W-1:0] ch_sensor,
    input  logic [NCH*W-1:0] ch_motor,
    output logic [NCH-1:0]   ch_ack,
    output logic [W-1:0]     ch_correction,
    output logic             ch_veto,
    output logic [W-1:0]     core_sensor,
    output logic [W-1:0]     core_motor,
    output logic             core_valid,
    input  logic             core_done,
    input  logic [W-1:0]     core_correction,
    input  logic             core_veto,
    output logic             busy,
    output logic             timeout_err
);
    localparam int IW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(VETO_HOLD + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

    typedef struct packed {
        logic [W-1:0] sensor;
        logic [W-1:0] motor;
    } chan_req_t;

    state_t           state;
    chan_req_t [NCH-1:0] req_v;
    logic [NCH-1:0]   lock_free;
    logic [NCH-1:0]   lock_load;
    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   grant_oh;
    logic [IW-1:0]    grant;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    cand;
    logic             pick_vld;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_nxt;
    logic             res_veto;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign req_v[i] = {ch_sensor[i*W +: W], ch_motor[i*W +: W]};

        psi_lock_lane #(
            .LW   (LW),
            .HOLD (VETO_HOLD)
        ) u_lock (
            .clk  (clk),
            .rst  (rst),
            .load (lock_load[i]),
            .free (lock_free[i])
        );
    end

    assign eligible  = ch_req & lock_free;
    assign grant_oh  = NCH'(1) << grant;
    assign lock_load = (state == RETIRE && res_veto) ? grant_oh : '0;
    assign timer_nxt = timer + TW'(1);

    // First eligible channel scanning upward from the one after last_grant.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = IW'((int'(last_grant) + k) % NCH);
            if (!pick_vld && eligible[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= IW'(NCH - 1);
            timer         <= '0;
            res_veto      <= 1'b0;
            core_sensor   <= '0;
            core_motor    <= '0;
            core_valid    <= 1'b0;
            ch_ack        <= '0;
            ch_correction <= '0;
            ch_veto       <= 1'b0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            core_valid  <= 1'b0;
            ch_ack      <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant       <= pick_idx;
                        core_sensor <= req_v[pick_idx].sensor;
                        core_motor  <= req_v[pick_idx].motor;
                        core_valid  <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer_nxt;
                    // A done arriving on the final WAIT cycle beats the timeout.
                    if (core_done) begin
                        res_veto      <= core_veto;
                        ch_ack        <= grant_oh;
                        ch_correction <= core_veto ? '0 : core_correction;
                        ch_veto       <= core_veto;
                        state         <= RETIRE;
                    end else if (timer_nxt == TW'(TIMEOUT)) begin
                        res_veto      <= 1'b0;
                        ch_ack        <= grant_oh;
                        ch_correction <= '0;
                        ch_veto       <= 1'b0;
                        timeout_err   <= 1'b1;
                        state         <= RETIRE;
                    end
                end
                RETIRE: begin
                    last_grant <= grant;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/psi_channel_scheduler.md
# psi_channel_scheduler

Time-multiplexes one shared reafference/ERN/PID/QGH processing core between NCH independent sensor–motor channels. Each channel issues one request at a time. The scheduler grants channels round-robin, presents the latched sensor/motor pair to the core, waits for the core's done strobe or a timeout, then returns the correction and veto to the granting channel. A channel that receives a veto is locked out for a programmable interval, which keeps a misbehaving effector from monopolising the core.

## Interface
- NCH, 4, number of requesting channels (2–8)
- W, 16, sensor/motor/correction word width
- TIMEOUT, 15, maximum WAIT cycles before abandoning a transaction (≥1)
- VETO_HOLD, 64, lockout cycles applied to a channel after a vetoed result (≥1)

- clk  in  1  single clock domain
- rst  in  1  asynchronous, active-high reset
- ch_req  in  NCH  per-channel request level
- ch_sensor  in  NCH*W  per-channel sensor scrape; channel i occupies [i*W +: W]
- ch_motor  in  NCH*W  per-channel motor command, same packing
- ch_ack  out  NCH  one-cycle completion pulse to the granted channel
- ch_correction  out  W  result word, valid while any ch_ack bit is high
- ch_veto  out  1  veto flag, valid with ch_ack
- core_sensor  out  W  latched sensor word driven to the core
- core_motor  out  W  latched motor word driven to the core
- core_valid  out  1  one-cycle issue strobe to the core
- core_done  in  1  core result strobe
- core_correction  in  W  core result, sampled with core_done
- core_veto  in  1  core veto, sampled with core_done
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse when a transaction times out

## Operation
- Reset values:
  - State = IDLE.
  - Outputs: all outputs 0.
  - Internal: last_grant = NCH-1, so channel 0 has first priority. All lockout counters 0. Wait timer 0.
- Eligibility: eligible[i] = ch_req[i] & (lock_cnt[i]==0).
- IDLE:
  - If any channel is eligible, grant the first eligible channel scanning from last_grant+1 modulo NCH.
  - Latch ch_sensor and ch_motor of the granted channel into core_sensor and core_motor, latch the grant index, then go to ISSUE.
  - Otherwise remain in IDLE.
- ISSUE: core_valid=1 for exactly this cycle; clear the timer; go to WAIT. core_done is ignored in ISSUE.
- WAIT:
  - Timer increments each cycle.
  - core_done=1: latch core_correction and core_veto, then go to RETIRE.
  - Otherwise, when the timer reaches TIMEOUT: latch correction=0 and veto=0, pulse timeout_err, then go to RETIRE.
  - If core_done and timeout coincide in the same cycle, done wins and there is no timeout_err.
- RETIRE:
  - ch_ack[grant]=1.
  - ch_correction = 0 if the latched veto is set, else the latched correction.
  - ch_veto = the latched veto.
  - Set last_grant = grant.
  - If the veto is set, load lock_cnt[grant] = VETO_HOLD.
  - Go to IDLE.
- Lockout counters decrement by 1 every cycle while nonzero, independent of state. A load in RETIRE overrides that cycle's decrement.
- core_sensor and core_motor hold their latched values until the next grant.
- A request dropped mid-transaction does not abort it: ch_ack still pulses and the result is discarded by the requester.
- ch_req sampled high in IDLE always counts as a new request. Requesters deassert on the edge where they sample ch_ack.
- Timer width is clog2(TIMEOUT+1). Lockout counter width is clog2(VETO_HOLD+1). Neither wraps.

## Timing
- All outputs are registered.
- Cycle sequence from request to acknowledge:
  - Cycle 0: req seen in IDLE.
  - Cycle 1: ISSUE, core_valid=1.
  - Cycle 2: first WAIT cycle.
  - Cycle 2+k: core_done arrives, where k = 0…TIMEOUT-1.
  - Cycle 3+k: RETIRE, ch_ack=1.
  - Cycle 4+k: IDLE.
- Minimum request-to-ack latency is 3 cycles. Back-to-back throughput is one transaction per 4 cycles at best.
- Timeout: RETIRE occurs TIMEOUT cycles after entering WAIT; timeout_err is high in the RETIRE cycle.
- A vetoed channel is ineligible for VETO_HOLD cycles after its ack; it is eligible again in the IDLE cycle where lock_cnt reads 0.
- Reset asserted in any state: all outputs return to 0 immediately (async). An in-flight transaction is abandoned with no ack, all lockouts clear, and last_grant returns to NCH-1.

## Test plan
- Single request: ch_req=0001, ch_sensor[0]=0x1234, ch_motor[0]=0x1200; core_done 1 cycle after WAIT entry with core_correction=0x0034, core_veto=0 → core_valid at cycle 1 with core_sensor=0x1234; ch_ack=0001 at cycle 4; ch_correction=0x0034, ch_veto=0.
- Round robin: ch_req=1111 held, core_done after 0 wait cycles each → grant order 0,1,2,3,0; each ack exactly 4 cycles apart.
- Veto lockout: channel 1 result has core_veto=1, core_correction=0x7FFF; ch_req=0011 held → ch_correction=0 and ch_veto=1; channel 1 gets no grant for 64 cycles while channel 0 is served; channel 1 is regranted afterwards.
- Timeout: ch_req=0100, core_done never asserted → timeout_err pulse and ch_ack=0100 with ch_correction=0 exactly 15 cycles after WAIT entry. Repeat with core_done in the 15th WAIT cycle → ack with the core result and no timeout_err.
- Reset mid-WAIT: assert rst during WAIT → busy, ch_ack, and core_valid go to 0 asynchronously. After release with ch_req=0011 → channel 0 is granted first.
- Request drop: deassert ch_req[2] during WAIT → ch_ack[2] still pulses; no re-grant of channel 2.
